// File: rtl/qif_pkg.sv
// Shared types and helpers for the QIF neuron bank: FSM state encoding,
// default neuron constants and the membrane saturation function.
package qif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int DEF_V_PEAK  = 4096;
    localparam int DEF_V_RESET = -256;
    localparam int DEF_LEAK    = 16;

    // Clamp a wide signed sum into the representable range of a w-bit signed membrane.
    function automatic logic signed [63:0] sat_v(input logic signed [63:0] s, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi) begin
            sat_v = hi;
        end else if (s < lo) begin
            sat_v = lo;
        end else begin
            sat_v = s;
        end
    endfunction

endpackage

// File: rtl/qif_update.sv
// Combinational single-neuron QIF step: V' = V + (V*V >> SQ_SHIFT) + B - LEAK.
// Optional refractory handling is compiled in with QIF_REFRACTORY_EN.
module qif_update
    import qif_pkg::*;
#(
    parameter int IN_W         = 8,
    parameter int V_W          = 16,
    parameter int SQ_SHIFT     = 8,
    parameter int LEAK         = DEF_LEAK,
    parameter int V_PEAK       = DEF_V_PEAK,
`ifdef QIF_REFRACTORY_EN
    parameter int REF_W        = 2,
    parameter int REFRAC_STEPS = 2,
`endif
    parameter int V_RESET      = DEF_V_RESET
) (
    input  logic signed [V_W-1:0]  v_i,
    input  logic        [IN_W-1:0] b_i,
`ifdef QIF_REFRACTORY_EN
    input  logic        [REF_W-1:0] ref_i,
    output logic        [REF_W-1:0] ref_o,
`endif
    output logic signed [V_W-1:0]  v_o,
    output logic                   spike_o
);

    localparam int SUM_W = 2 * V_W + 2;
    localparam logic signed [SUM_W-1:0] LEAK_S  = SUM_W'(LEAK);
    localparam logic signed [SUM_W-1:0] PEAK_S  = SUM_W'(V_PEAK);
    localparam logic signed [V_W-1:0]   RESET_S = V_W'(V_RESET);
`ifdef QIF_REFRACTORY_EN
    localparam logic [REF_W-1:0]        REF_LOAD = REF_W'(REFRAC_STEPS);
`endif

    logic signed [2*V_W-1:0] v_ext_s;
    logic        [2*V_W-1:0] sq_s;
    logic signed [SUM_W-1:0] sum_s;
    logic                    cross_s;

    // Square, sum and threshold test; the spike decision uses the unsaturated sum.
    always_comb begin
        v_ext_s = {{V_W{v_i[V_W-1]}}, v_i};
        sq_s    = $unsigned(v_ext_s * v_ext_s);
        sum_s   = {{2{v_ext_s[2*V_W-1]}}, v_ext_s}
                + {2'b00, (sq_s >> SQ_SHIFT)}
                + {{(SUM_W - IN_W){1'b0}}, b_i}
                - LEAK_S;
        cross_s = (sum_s >= PEAK_S);
    end

    // Select the new membrane value and spike flag.
    always_comb begin
        v_o     = V_W'(sat_v(64'(sum_s), V_W));
        spike_o = 1'b0;
`ifdef QIF_REFRACTORY_EN
        ref_o   = {REF_W{1'b0}};
        if (ref_i != {REF_W{1'b0}}) begin
            v_o   = RESET_S;
            ref_o = ref_i - REF_W'(1);
        end else if (cross_s) begin
            v_o     = RESET_S;
            spike_o = 1'b1;
            ref_o   = REF_LOAD;
        end else begin
            ref_o = {REF_W{1'b0}};
        end
`else
        if (cross_s) begin
            v_o     = RESET_S;
            spike_o = 1'b1;
        end else begin
            spike_o = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/qif_neuron_bank.sv
// Bank of NUM_CH QIF neurons sharing one time-multiplexed qif_update datapath.
// Define QIF_REFRACTORY_EN to add per-channel refractory counters.
module qif_neuron_bank
    import qif_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int IN_W         = 8,
    parameter int V_W          = 16,
    parameter int SQ_SHIFT     = 8,
    parameter int LEAK         = DEF_LEAK,
    parameter int V_PEAK       = DEF_V_PEAK,
    parameter int V_RESET      = DEF_V_RESET,
    parameter int REFRAC_STEPS = 2,
    localparam int IDX_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     step,
    input  logic [NUM_CH*IN_W-1:0]   b_in,
    input  logic [IDX_W-1:0]         mon_sel,
    output logic                     busy,
    output logic                     step_done,
    output logic [NUM_CH-1:0]        spike_vec,
    output logic                     spike_valid,
    output logic [IDX_W-1:0]         spike_ch,
    output logic signed [V_W-1:0]    v_mon
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic [IDX_W:0]   NUM_CH_L = (IDX_W + 1)'(NUM_CH);
    localparam int REF_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

    if (NUM_CH < 1 || REFRAC_STEPS < 0) begin : g_bad_cfg
        $error("qif_neuron_bank: NUM_CH must be >= 1 and REFRAC_STEPS >= 0");
    end

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [NUM_CH*IN_W-1:0]  b_q;
    logic signed [V_W-1:0]   v_q [NUM_CH];
    logic [NUM_CH-1:0]       spike_acc_q;
    logic                    busy_q;
    logic                    step_done_q;
    logic [NUM_CH-1:0]       spike_vec_q;
    logic                    spike_valid_q;
    logic [IDX_W-1:0]        spike_ch_q;
    logic signed [V_W-1:0]   v_mon_q;

    logic signed [V_W-1:0]   cur_v_s;
    logic [IN_W-1:0]         cur_b_s;
    logic signed [V_W-1:0]   new_v_s;
    logic                    new_spike_s;
    logic [IDX_W-1:0]        mon_idx_s;

`ifdef QIF_REFRACTORY_EN
    logic [REF_W-1:0]        ref_q [NUM_CH];
    logic [REF_W-1:0]        cur_ref_s;
    logic [REF_W-1:0]        new_ref_s;
`endif

    // Operand fetch for the channel being updated and a range-safe monitor index.
    always_comb begin
        cur_v_s = v_q[idx_q];
        cur_b_s = b_q[int'(idx_q) * IN_W +: IN_W];
`ifdef QIF_REFRACTORY_EN
        cur_ref_s = ref_q[idx_q];
`endif
        if ({1'b0, mon_sel} < NUM_CH_L) begin
            mon_idx_s = mon_sel;
        end else begin
            mon_idx_s = {IDX_W{1'b0}};
        end
    end

    qif_update #(
        .IN_W         (IN_W),
        .V_W          (V_W),
        .SQ_SHIFT     (SQ_SHIFT),
        .LEAK         (LEAK),
        .V_PEAK       (V_PEAK),
`ifdef QIF_REFRACTORY_EN
        .REF_W        (REF_W),
        .REFRAC_STEPS (REFRAC_STEPS),
`endif
        .V_RESET      (V_RESET)
    ) u_update (
        .v_i     (cur_v_s),
        .b_i     (cur_b_s),
`ifdef QIF_REFRACTORY_EN
        .ref_i   (cur_ref_s),
        .ref_o   (new_ref_s),
`endif
        .v_o     (new_v_s),
        .spike_o (new_spike_s)
    );

    // Step sequencer, neuron state arrays and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= {IDX_W{1'b0}};
            b_q           <= {(NUM_CH*IN_W){1'b0}};
            spike_acc_q   <= {NUM_CH{1'b0}};
            busy_q        <= 1'b0;
            step_done_q   <= 1'b0;
            spike_vec_q   <= {NUM_CH{1'b0}};
            spike_valid_q <= 1'b0;
            spike_ch_q    <= {IDX_W{1'b0}};
            v_mon_q       <= {V_W{1'b0}};
            for (int k = 0; k < NUM_CH; k++) begin
                v_q[k] <= {V_W{1'b0}};
`ifdef QIF_REFRACTORY_EN
                ref_q[k] <= {REF_W{1'b0}};
`endif
            end
        end else begin
            step_done_q   <= 1'b0;
            spike_valid_q <= 1'b0;
            v_mon_q       <= v_q[mon_idx_s];
            case (state_q)
                ST_IDLE: begin
                    if (step) begin
                        b_q         <= b_in;
                        idx_q       <= {IDX_W{1'b0}};
                        spike_acc_q <= {NUM_CH{1'b0}};
                        busy_q      <= 1'b1;
                        state_q     <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    v_q[idx_q]         <= new_v_s;
`ifdef QIF_REFRACTORY_EN
                    ref_q[idx_q]       <= new_ref_s;
`endif
                    spike_acc_q[idx_q] <= new_spike_s;
                    spike_valid_q      <= new_spike_s;
                    spike_ch_q         <= idx_q;
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    // Publish the whole step's spikes together with the done pulse.
                    spike_vec_q <= spike_acc_q;
                    step_done_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign step_done   = step_done_q;
    assign spike_vec   = spike_vec_q;
    assign spike_valid = spike_valid_q;
    assign spike_ch    = spike_ch_q;
    assign v_mon       = v_mon_q;

endmodule

// File: tb/tb_qif_neuron_bank.sv
// Self-checking bench for qif_neuron_bank: step table with a spike scoreboard,
// plus held-step, mid-step reset and saturation sequences.
module tb_qif_neuron_bank;

`ifdef QIF_REFRACTORY_EN
    localparam bit REF_EN = 1'b1;
`else
    localparam bit REF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        step = 1'b0;
    logic [31:0] b_in = 32'd0;
    logic [1:0]  mon_sel = 2'd0;
    logic        busy, step_done, spike_valid;
    logic [3:0]  spike_vec;
    logic [1:0]  spike_ch;
    logic signed [15:0] v_mon;

    logic        step2 = 1'b0;
    logic [15:0] b_in2 = 16'd0;
    logic [0:0]  mon_sel2 = 1'b0;
    logic        busy2, step_done2, spike_valid2;
    logic [1:0]  spike_vec2;
    logic [0:0]  spike_ch2;
    logic signed [15:0] v_mon2;

    always #5 clk = ~clk;

    qif_neuron_bank dut (
        .clk(clk), .rst_n(rst_n), .step(step), .b_in(b_in), .mon_sel(mon_sel),
        .busy(busy), .step_done(step_done), .spike_vec(spike_vec),
        .spike_valid(spike_valid), .spike_ch(spike_ch), .v_mon(v_mon)
    );

    qif_neuron_bank #(.NUM_CH(2), .SQ_SHIFT(31), .LEAK(10000), .V_PEAK(32767)) dut_sat (
        .clk(clk), .rst_n(rst_n), .step(step2), .b_in(b_in2), .mon_sel(mon_sel2),
        .busy(busy2), .step_done(step_done2), .spike_vec(spike_vec2),
        .spike_valid(spike_valid2), .spike_ch(spike_ch2), .v_mon(v_mon2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] sv_q[$];
    int         ch_q[$];

    typedef struct {
        bit          rst_first;
        logic [31:0] b;
        int          ev[4];
        logic [3:0]  esv;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard: pop expected spike vector / spiking channel when the DUT reports them.
    always @(negedge clk) begin
        if (step_done) begin
            if (sv_q.size() == 0) chk("step_done_unexpected", 1, 0);
            else chk("spike_vec", int'(spike_vec), int'(sv_q.pop_front()));
        end
        if (spike_valid) begin
            if (ch_q.size() == 0) chk("spike_valid_unexpected", int'(spike_ch), -1);
            else chk("spike_ch", int'(spike_ch), ch_q.pop_front());
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; step = 1'b0; step2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_step_done", int'(step_done), 0);
        chk("rst_spike_vec", int'(spike_vec), 0);
        chk("rst_v_mon", int'(v_mon), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_step(input logic [31:0] b, input logic [3:0] esv);
        int cnt;
        sv_q.push_back(esv);
        for (int k = 0; k < 4; k++) if (esv[k]) ch_q.push_back(k);
        @(negedge clk);
        b_in = b; step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        chk("busy_after_accept", int'(busy), 1);
        cnt = 0;
        while (!step_done && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("done_latency", cnt, 5);
        @(negedge clk);
    endtask

    task automatic check_v(input int k, input int exp);
        @(negedge clk);
        mon_sel = 2'(k);
        @(posedge clk);
        #1;
        chk($sformatf("v_ch%0d", k), int'(v_mon), exp);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        tbl[0] = '{1'b1, 32'h0000_0000, '{-16, -16, -16, -16}, 4'b0000};
        tbl[1] = '{1'b0, 32'h0000_0000, '{-31, -31, -31, -31}, 4'b0000};
        tbl[2] = '{1'b1, 32'h0000_00FF, '{239, -16, -16, -16}, 4'b0000};
        tbl[3] = '{1'b0, 32'h0000_00FF, '{701, -31, -31, -31}, 4'b0000};
        tbl[4] = '{1'b0, 32'h0000_00FF, '{2859, -44, -44, -44}, 4'b0000};
        tbl[5] = '{1'b0, 32'h0000_00FF, '{-256, -53, -53, -53}, 4'b0001};
        tbl[6] = '{1'b0, 32'h0000_00FF, '{REF_EN ? -256 : 239, -59, -59, -59}, 4'b0000};
        tbl[7] = '{1'b0, 32'h0000_00FF, '{REF_EN ? -256 : 701, -62, -62, -62}, 4'b0000};
        tbl[8] = '{1'b0, 32'h0000_00FF, '{REF_EN ? 239 : 2859, -63, -63, -63}, 4'b0000};
        tbl[9] = '{1'b1, 32'h1064_00C8, '{184, -16, 84, 0}, 4'b0000};

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].rst_first) do_reset();
            do_step(tbl[i].b, tbl[i].esv);
            for (int k = 0; k < 4; k++) check_v(k, tbl[i].ev[k]);
        end

        // step held high across a whole step: only one step may run
        do_reset();
        sv_q.push_back(4'b0000);
        @(negedge clk);
        b_in = 32'd0; step = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        step = 1'b0;
        repeat (8) @(posedge clk);
        check_v(0, -16);
        check_v(3, -16);

        // reset asserted in the middle of UPDATE
        do_reset();
        @(negedge clk);
        b_in = 32'd0; step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_spike_vec", int'(spike_vec), 0);
        chk("midrst_v_mon", int'(v_mon), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        check_v(0, 0);
        check_v(1, 0);
        do_step(32'd0, 4'b0000);
        check_v(0, -16);
        check_v(2, -16);

        // saturation at the negative rail on the large-leak instance
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            step2 = 1'b1;
            @(posedge clk);
            #1;
            step2 = 1'b0;
            cnt = 0;
            while (!step_done2 && cnt < 20) begin
                @(posedge clk);
                #1;
                cnt++;
            end
            chk("sat_done_latency", cnt, 3);
            @(negedge clk);
            mon_sel2 = 1'b0;
            @(posedge clk);
            #1;
            chk($sformatf("sat_v0_step%0d", s + 1), int'(v_mon2), (s < 3) ? -10000 * (s + 1) : -32768);
        end
        @(negedge clk);
        mon_sel2 = 1'b1;
        @(posedge clk);
        #1;
        chk("sat_v1", int'(v_mon2), -32768);
        chk("sat_spike_vec", int'(spike_vec2), 0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sv_q.size() + ch_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
